uart_msg_sender: RTL and testbench

- Upstream byte sequencer for the game's serial transmitter.
- On a single-cycle `start`, latches a result code and a guess value. It converts the value to two ASCII decimal digits, then streams a fixed-format text line, one byte at a time, into the UART transmitter.
- Byte handoff uses the transmitter's `send`/`busy` handshake. Game control logic sees only `start`, `msg_busy` and `done`.

---
 rtl/uart_msg_sender.sv | 193 +++++++++++++++++++
 tb/tb_uart_msg_sender.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_sender.sv
// Byte sequencer that formats "<WORD> <tens><ones><EOL>" and feeds it,
// one byte per send/busy handshake, into the UART transmitter.
module uart_msg_sender #(
  parameter bit EOL_CRLF = 1'b1,
  parameter int VAL_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       code,
  input  logic [VAL_W-1:0] value,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_send,
  output logic             msg_busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONV    = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [3:0] IDX_CR   = 4'd7;
  localparam logic [3:0] IDX_LAST = 4'd8;

  logic [2:0] state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [6:0] rem_q, rem_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;

  logic [6:0] val_clamp;
  logic [7:0] word_byte;
  logic [7:0] cur_byte;
  logic [3:0] idx_next;

  always_comb begin
    val_clamp = 7'd99;
    if (32'(value) <= 32'd99) begin
      val_clamp = 7'(value);
    end
  end

  always_comb begin
    word_byte = 8'h20;
    unique case (code_q)
      2'd0: begin
        unique case (idx_q[1:0])
          2'd0: word_byte = 8'h4C;
          2'd1: word_byte = 8'h4F;
          2'd2: word_byte = 8'h57;
          default: word_byte = 8'h20;
        endcase
      end
      2'd1: begin
        unique case (idx_q[1:0])
          2'd0: word_byte = 8'h48;
          2'd1: word_byte = 8'h49;
          2'd2: word_byte = 8'h47;
          default: word_byte = 8'h48;
        endcase
      end
      2'd2: begin
        unique case (idx_q[1:0])
          2'd0: word_byte = 8'h57;
          2'd1: word_byte = 8'h49;
          2'd2: word_byte = 8'h4E;
          default: word_byte = 8'h21;
        endcase
      end
      default: begin
        unique case (idx_q[1:0])
          2'd0: word_byte = 8'h4E;
          2'd1: word_byte = 8'h45;
          2'd2: word_byte = 8'h57;
          default: word_byte = 8'h20;
        endcase
      end
    endcase
  end

  // After CONV, rem_q holds the ones digit (0..9).
  always_comb begin
    cur_byte = 8'h0A;
    unique case (1'b1)
      (idx_q < 4'd4):    cur_byte = word_byte;
      (idx_q == 4'd4):   cur_byte = 8'h20;
      (idx_q == 4'd5):   cur_byte = {4'h3, tens_q};
      (idx_q == 4'd6):   cur_byte = {4'h3, rem_q[3:0]};
      (idx_q == IDX_CR): cur_byte = 8'h0D;
      default:           cur_byte = 8'h0A;
    endcase
  end

  always_comb begin
    idx_next = idx_q + 4'd1;
    if (!EOL_CRLF && (idx_q == 4'd6)) begin
      idx_next = IDX_LAST;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    idx_d   = idx_q;
    data_d  = data_q;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d  = code;
          rem_d   = val_clamp;
          tens_d  = 4'd0;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (rem_q >= 7'd10) begin
          rem_d  = rem_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        data_d = cur_byte;
        if (!tx_busy) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_next;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= 2'd0;
      rem_q   <= 7'd0;
      tens_q  <= 4'd0;
      idx_q   <= 4'd0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      rem_q   <= rem_d;
      tens_q  <= tens_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // The byte is visible in the LOAD cycle itself so the send pulse
  // and its data line up; elsewhere the last byte is held.
  assign tx_data  = (state_q == S_LOAD) ? cur_byte : data_q;
  assign tx_send  = (state_q == S_LOAD) && !tx_busy;
  assign done     = (state_q == S_DONE);
  assign msg_busy = busy_q;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Bench for uart_msg_sender: CRLF and LF-only instances, each driving
// a simple transmitter model; bytes checked against a text-level model.
module tb_uart_msg_sender;

  localparam int TX_CYC = 40;
  localparam logic [31:0] WORDS [4] = '{
    32'h4C4F5720, 32'h48494748, 32'h57494E21, 32'h4E455720
  };

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic            rst;
  logic [1:0]      start_r;
  logic [1:0][1:0] code_r;
  logic [1:0][6:0] val_r;
  logic [1:0]      ext_hold;
  logic [1:0]      tx_busy_w;
  logic [1:0][7:0] tx_data_w;
  logic [1:0]      tx_send_w;
  logic [1:0]      msg_busy_w;
  logic [1:0]      done_w;

  int cnt [2] = '{0, 0};

  uart_msg_sender #(.EOL_CRLF(1'b1), .VAL_W(7)) dut0 (
    .clk(clk), .rst(rst), .start(start_r[0]), .code(code_r[0]),
    .value(val_r[0]), .tx_busy(tx_busy_w[0]), .tx_data(tx_data_w[0]),
    .tx_send(tx_send_w[0]), .msg_busy(msg_busy_w[0]), .done(done_w[0])
  );

  uart_msg_sender #(.EOL_CRLF(1'b0), .VAL_W(7)) dut1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .code(code_r[1]),
    .value(val_r[1]), .tx_busy(tx_busy_w[1]), .tx_data(tx_data_w[1]),
    .tx_send(tx_send_w[1]), .msg_busy(msg_busy_w[1]), .done(done_w[1])
  );

  // Transmitter: accepts a send when idle, busy from the next cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_send_w[i] && cnt[i] == 0) cnt[i] <= TX_CYC;
      else if (cnt[i] != 0) cnt[i] <= cnt[i] - 1;
    end
  end
  assign tx_busy_w[0] = (cnt[0] != 0) | ext_hold[0];
  assign tx_busy_w[1] = (cnt[1] != 0) | ext_hold[1];

  int          ncap [2] = '{0, 0};
  logic [7:0]  cap [2][16];
  int          viol [2] = '{0, 0};
  int          ndone [2] = '{0, 0};
  bit   [1:0]  infl = '0;
  bit   [1:0]  seen_hi = '0;
  bit   [1:0]  prev_done = '0;
  logic [1:0][7:0] held;

  // Protocol monitor: capture, data stability, send spacing, done shape.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        infl[i] = 1'b0;
        prev_done[i] = 1'b0;
      end else begin
        if (infl[i]) begin
          if (tx_data_w[i] != held[i]) viol[i]++;
          if (tx_busy_w[i]) seen_hi[i] = 1'b1;
          else if (seen_hi[i]) infl[i] = 1'b0;
        end
        if (tx_send_w[i]) begin
          if (infl[i] || tx_busy_w[i]) viol[i]++;
          infl[i] = 1'b1;
          seen_hi[i] = 1'b0;
          held[i] = tx_data_w[i];
          if (ncap[i] < 16) cap[i][ncap[i]] = tx_data_w[i];
          ncap[i]++;
        end
        if (done_w[i]) begin
          ndone[i]++;
          if (!msg_busy_w[i] || prev_done[i]) viol[i]++;
        end
        if (prev_done[i] && msg_busy_w[i]) viol[i]++;
        prev_done[i] = done_w[i];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] exp_b [9];
  int nexp;
  int exp_conv;

  task automatic build_exp(input int inst, input int c, input int v);
    logic [31:0] w;
    int vv;
    w  = WORDS[c];
    vv = (v > 99) ? 99 : v;
    for (int k = 0; k < 4; k++) exp_b[k] = w[31-8*k -: 8];
    exp_b[4] = 8'h20;
    exp_b[5] = 8'(48 + vv / 10);
    exp_b[6] = 8'(48 + vv % 10);
    nexp = 7;
    if (inst == 0) begin
      exp_b[nexp] = 8'h0D;
      nexp++;
    end
    exp_b[nexp] = 8'h0A;
    nexp++;
    exp_conv = vv / 10 + 1;
  endtask

  task automatic run_msg(input int inst, input int c, input int v,
                         input int hold, input bit mid, input bit poke);
    int cyc;
    int t;
    build_exp(inst, c, v);
    ncap[inst] = 0;
    viol[inst] = 0;
    ndone[inst] = 0;
    ext_hold[inst] = (hold > 0);
    code_r[inst] = 2'(c);
    val_r[inst] = 7'(v);
    start_r[inst] = 1'b1;
    tick();
    start_r[inst] = 1'b0;
    chk("msg_busy_rise", int'(msg_busy_w[inst]), 1);
    cyc = 0;
    while (!tx_send_w[inst] && cyc < hold + 100) begin
      tick();
      cyc++;
      if (hold > 0 && cyc == hold) begin
        ext_hold[inst] = 1'b0;
        #1;
      end
    end
    if (hold > 0) chk("hold_release", cyc, hold);
    else chk("conv_cycles", cyc, exp_conv);
    if (mid) begin
      t = 0;
      while (ncap[inst] < 3 && t < 1000) begin
        tick();
        t++;
      end
      code_r[inst] = 2'd3;
      val_r[inst] = 7'd55;
      start_r[inst] = 1'b1;
      tick();
      start_r[inst] = 1'b0;
    end
    t = 0;
    while (!done_w[inst] && t < 4000) begin
      tick();
      t++;
    end
    chk("done_seen", int'(done_w[inst]), 1);
    chk("busy_at_done", int'(msg_busy_w[inst]), 1);
    chk("nbytes", ncap[inst], nexp);
    for (int k = 0; k < nexp; k++)
      chk($sformatf("byte%0d", k), int'(cap[inst][k]), int'(exp_b[k]));
    if (poke) begin
      code_r[inst] = 2'd0;
      val_r[inst] = 7'd11;
      start_r[inst] = 1'b1;
    end
    tick();
    start_r[inst] = 1'b0;
    chk("done_count", ndone[inst], 1);
    chk("busy_after", int'(msg_busy_w[inst]), 0);
    chk("protocol", viol[inst], 0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    start_r = '0;
    code_r = '0;
    val_r = '0;
    ext_hold = '0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_data", int'(tx_data_w[i]), 0);
      chk("rst_send", int'(tx_send_w[i]), 0);
      chk("rst_busy", int'(msg_busy_w[i]), 0);
      chk("rst_done", int'(done_w[i]), 0);
    end
    rst = 1'b0;
    repeat (100) tick();
    chk("idle_sends", ncap[0] + ncap[1], 0);

    run_msg(0, 0, 42, 0, 1'b0, 1'b0);
    run_msg(0, 2, 120, 0, 1'b0, 1'b0);
    run_msg(0, 2, 0, 0, 1'b0, 1'b0);
    run_msg(1, 1, 7, 0, 1'b0, 1'b0);
    run_msg(0, 1, 63, 0, 1'b1, 1'b1);
    run_msg(0, 3, 18, 0, 1'b0, 1'b0);
    run_msg(0, 2, 5, 50, 1'b0, 1'b0);
    run_msg(1, 0, 99, 50, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_msg(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 127)), 0, 1'b0, 1'b0);
    end

    ncap[0] = 0;
    code_r[0] = 2'd1;
    val_r[0] = 7'd77;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    t = 0;
    while (ncap[0] < 4 && t < 2000) begin
      tick();
      t++;
    end
    chk("mid_reached", ncap[0], 4);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", int'(tx_data_w[0]), 0);
    chk("mid_rst_send", int'(tx_send_w[0]), 0);
    chk("mid_rst_busy", int'(msg_busy_w[0]), 0);
    chk("mid_rst_done", int'(done_w[0]), 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (200) tick();
    chk("post_rst_sends", ncap[0], 4);
    chk("post_rst_busy", int'(msg_busy_w[0]), 0);

    run_msg(0, 3, 9, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
